prog_frequency_divider: RTL and testbench

//   Runtime-programmable successor to the fixed frequency divider. Divides clk by
//   a programmable period P with programmable high time H, square or pulse mode.

---
 rtl/prog_freq_div_pkg.sv | 16 +
 rtl/freq_div_cfg_shadow.sv | 70 +++++++
 rtl/prog_frequency_divider.sv | 95 +++++++++
 tb/tb_prog_frequency_divider.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_freq_div_pkg.sv
// Shared types and constants for the programmable frequency divider.
package prog_freq_div_pkg;

    typedef enum logic {
        SQUARE = 1'b0,
        PULSE  = 1'b1
    } div_mode_e;

    localparam int MIN_PERIOD = 2;

    // A period below MIN_PERIOD would make P-1 zero or wrap, so it is refused.
    function automatic logic period_ok(input logic [31:0] period);
        return period >= 32'(MIN_PERIOD);
    endfunction

endpackage

// File: rtl/freq_div_cfg_shadow.sv
// Configuration handshake: validates offered settings, holds them in a shadow
// register and flags them pending until the counter core applies them.
import prog_freq_div_pkg::*;

module freq_div_cfg_shadow #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_high,
    input  logic         cfg_mode,
    input  logic         apply,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         pending,
    output logic [W-1:0] shadow_period,
    output logic [W-1:0] shadow_high,
    output logic         shadow_mode
);

    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] high;
        div_mode_e    mode;
    } div_cfg_t;

    div_cfg_t shadow_reg, shadow_next;
    logic     pending_reg, pending_next;
    logic     err_reg, err_next;
    logic     accept;
    logic     period_valid;

    assign accept       = cfg_valid & ~pending_reg;
    assign period_valid = period_ok(32'(cfg_period));

    always_comb begin
        shadow_next  = shadow_reg;
        pending_next = pending_reg;
        err_next     = accept & ~period_valid;
        // apply only fires while pending, and no accept can occur while pending
        if (apply) begin
            pending_next = 1'b0;
        end else if (accept && period_valid) begin
            pending_next = 1'b1;
            shadow_next  = '{cfg_period, cfg_high, div_mode_e'(cfg_mode)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg  <= '{'0, '0, SQUARE};
            pending_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            shadow_reg  <= shadow_next;
            pending_reg <= pending_next;
            err_reg     <= err_next;
        end
    end

    assign cfg_ready     = ~pending_reg;
    assign cfg_err       = err_reg;
    assign pending       = pending_reg;
    assign shadow_period = shadow_reg.period;
    assign shadow_high   = shadow_reg.high;
    assign shadow_mode   = shadow_reg.mode;

endmodule

// File: rtl/prog_frequency_divider.sv
// Runtime-programmable clock divider: period P, high time H, square or pulse
// output, with new settings swapped in only at a period boundary or while idle.
import prog_freq_div_pkg::*;

module prog_frequency_divider #(
    parameter int W              = 16,
    parameter int DEFAULT_PERIOD = 18,
    parameter int DEFAULT_HIGH   = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_high,
    input  logic         cfg_mode,
    output logic         cfg_err,
    output logic         divider_out,
    output logic         tick
);

    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] high;
        div_mode_e    mode;
    } div_cfg_t;

    div_cfg_t     active_reg, active_next;
    logic [W-1:0] cnt_reg, cnt_next;
    logic         out_reg, out_next;
    logic         tick_reg, tick_next;
    logic         wrap;
    logic         apply;
    logic         pending;
    logic [W-1:0] shadow_period;
    logic [W-1:0] shadow_high;
    logic         shadow_mode;

    freq_div_cfg_shadow #(
        .W(W)
    ) u_cfg_shadow (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_period   (cfg_period),
        .cfg_high     (cfg_high),
        .cfg_mode     (cfg_mode),
        .apply        (apply),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .pending      (pending),
        .shadow_period(shadow_period),
        .shadow_high  (shadow_high),
        .shadow_mode  (shadow_mode)
    );

    assign wrap  = (cnt_reg == active_reg.period - W'(1));
    assign apply = pending & (~en | wrap);

    always_comb begin
        active_next = active_reg;
        cnt_next    = '0;
        out_next    = 1'b0;
        tick_next   = 1'b0;
        if (en) begin
            tick_next = wrap;
            out_next  = (active_reg.mode == PULSE) ? wrap : (cnt_reg < active_reg.high);
            cnt_next  = wrap ? '0 : cnt_reg + W'(1);
        end
        // outputs above still reflect the old settings on the swap edge
        if (apply) begin
            active_next = '{shadow_period, shadow_high, div_mode_e'(shadow_mode)};
            cnt_next    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= '{W'(DEFAULT_PERIOD), W'(DEFAULT_HIGH), SQUARE};
            cnt_reg    <= '0;
            out_reg    <= 1'b0;
            tick_reg   <= 1'b0;
        end else begin
            active_reg <= active_next;
            cnt_reg    <= cnt_next;
            out_reg    <= out_next;
            tick_reg   <= tick_next;
        end
    end

    assign divider_out = out_reg;
    assign tick        = tick_reg;

endmodule

// File: tb/tb_prog_frequency_divider.sv
// Directed and randomized checks of the programmable divider against a
// cycle-level behavioural model of its period/high-time rules.
module tb_prog_frequency_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_period = '0;
    logic [W-1:0] cfg_high = '0;
    logic         cfg_mode = 1'b0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         divider_out;
    logic         tick;

    int checks = 0;
    int failures = 0;

    // model state: position within period, active and shadow settings
    int m_cnt, m_p, m_h;
    bit m_mode, m_pend, m_out, m_tick, m_err;
    int s_p, s_h;
    bit s_mode;

    prog_frequency_divider #(
        .W(W),
        .DEFAULT_PERIOD(18),
        .DEFAULT_HIGH(9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_mode   (cfg_mode),
        .cfg_err    (cfg_err),
        .divider_out(divider_out),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        m_cnt = 0; m_p = 18; m_h = 9; m_mode = 0; m_pend = 0;
        m_out = 0; m_tick = 0; m_err = 0;
    endfunction

    // One clock edge of the spec's rules, evaluated from pre-edge state and inputs.
    function automatic void model_edge();
        bit last, apply, accept;
        if (!rst_n) begin
            model_reset();
            return;
        end
        last   = (m_cnt == m_p - 1);
        apply  = m_pend && (!en || last);
        accept = cfg_valid && !m_pend;
        if (en) begin
            m_tick = last;
            m_out  = m_mode ? last : (m_cnt < m_h);
            m_cnt  = last ? 0 : m_cnt + 1;
        end else begin
            m_tick = 0;
            m_out  = 0;
            m_cnt  = 0;
        end
        m_err = accept && (int'(cfg_period) < 2);
        if (apply) begin
            m_p = s_p; m_h = s_h; m_mode = s_mode; m_cnt = 0; m_pend = 0;
        end else if (accept && int'(cfg_period) >= 2) begin
            s_p = int'(cfg_period); s_h = int'(cfg_high); s_mode = cfg_mode; m_pend = 1;
        end
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("divider_out", divider_out, m_out);
        chk("tick", tick, m_tick);
        chk("cfg_err", cfg_err, m_err);
        chk("cfg_ready", cfg_ready, !m_pend);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic offer(input int p, input int h, input bit mode);
        cfg_period = W'(p);
        cfg_high   = W'(h);
        cfg_mode   = mode;
        cfg_valid  = 1'b1;
        step();
        cfg_valid  = 1'b0;
    endtask

    // Independent check: spacing between two consecutive tick strobes.
    task automatic measure_period(input string tag, input int exp);
        int first = -1;
        int n = 0;
        bit done = 0;
        while (n < 200 && !done) begin
            step();
            n++;
            if (tick) begin
                if (first < 0) first = n;
                else done = 1;
            end
        end
        if (done) chk_int(tag, n - first, exp);
        else chk_int({tag, "_timeout"}, n, -1);
    endtask

    initial begin
        model_reset();
        s_p = 0; s_h = 0; s_mode = 0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_divider_out", divider_out, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        rst_n = 1'b1;
        run(2);

        // default 9 high / 9 low, tick every 18
        en = 1'b1;
        run(40);
        measure_period("default_period", 18);

        // P=4,H=1 offered mid-period
        run(5);
        offer(4, 1, 1'b0);
        run(30);
        measure_period("p4_period", 4);

        // rejected P=1: period stays 4
        offer(1, 0, 1'b0);
        run(12);
        measure_period("p1_rejected_period", 4);

        // H=0 then H>=P
        offer(5, 0, 1'b0);
        run(15);
        measure_period("h0_period", 5);
        offer(5, 7, 1'b0);
        run(15);
        measure_period("hbig_period", 5);

        // pulse mode P=3
        offer(3, 1, 1'b1);
        run(12);
        chk("pulse_equals_tick", divider_out, tick);
        measure_period("pulse_period", 3);

        // en low mid-period applies pending P=6
        run(1);
        offer(6, 2, 1'b0);
        run(1);
        en = 1'b0;
        step();
        chk("en_low_out", divider_out, 1'b0);
        en = 1'b1;
        run(10);
        measure_period("en_apply_period", 6);

        // async reset with a pending config
        run(2);
        offer(10, 3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", divider_out, 1'b0);
        chk("async_rst_tick", tick, 1'b0);
        chk("async_rst_ready", cfg_ready, 1'b1);
        model_reset();
        run(2);
        rst_n = 1'b1;
        run(20);
        measure_period("post_rst_period", 18);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cfg_valid  = ($urandom_range(0, 7) == 0);
            cfg_period = W'($urandom_range(0, 12));
            cfg_high   = W'($urandom_range(0, 14));
            cfg_mode   = 1'($urandom_range(0, 1));
            en         = ($urandom_range(0, 19) != 0);
            step();
        end
        cfg_valid = 1'b0;
        en = 1'b1;
        run(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
